// File: rtl/cluster_packer_seq_if.sv
// Frame/result bundle of the S-bit cluster packer: one hit frame in, up to
// MXCLUSTERS {cnt,adr} cluster words out with status and drop accounting.
interface cluster_packer_seq_if #(
  parameter int unsigned MXROWS     = 8,
  parameter int unsigned MXKEYS     = 192,
  parameter int unsigned MXCNTBITS  = 3,
  parameter int unsigned MXADRBITS  = 11,
  parameter int unsigned MXCLUSTERS = 8
);
  localparam int unsigned MXCLSTBITS = MXCNTBITS + MXADRBITS;
  localparam int unsigned CCW        = $clog2(MXCLUSTERS + 1);

  logic                             reverse_priority_order;
  logic                             truncate_clusters;
  logic                             sbits_valid;
  logic [MXROWS*MXKEYS-1:0]         sbits;
  logic                             busy;
  logic                             clusters_valid;
  logic [MXCLUSTERS*MXCLSTBITS-1:0] clusters;
  logic [CCW-1:0]                   cluster_count;
  logic                             overflow;
  logic [15:0]                      dropped_cnt;

  modport master (
    output reverse_priority_order, truncate_clusters, sbits_valid, sbits,
    input  busy, clusters_valid, clusters, cluster_count, overflow, dropped_cnt
  );

  modport slave (
    input  reverse_priority_order, truncate_clusters, sbits_valid, sbits,
    output busy, clusters_valid, clusters, cluster_count, overflow, dropped_cnt
  );
endinterface

// File: rtl/cluster_packer_seq.sv
// Sequential S-bit cluster packer: registers a frame, marks cluster starts and
// sizes, then extracts one cluster per clock in selectable priority order.
module cluster_packer_seq #(
  parameter int unsigned MXROWS     = 8,
  parameter int unsigned MXKEYS     = 192,
  parameter int unsigned MXCNTBITS  = 3,
  parameter int unsigned MXADRBITS  = 11,
  parameter int unsigned MXCLUSTERS = 8
) (
  input  logic                 clock4x,
  input  logic                 global_reset_n,
  cluster_packer_seq_if.slave  bus
);
  localparam int unsigned NPADS      = MXROWS * MXKEYS;
  localparam int unsigned CHUNK      = 2 ** MXCNTBITS;
  localparam int unsigned MXCLSTBITS = MXCNTBITS + MXADRBITS;
  localparam int unsigned CCW        = $clog2(MXCLUSTERS + 1);
  localparam int unsigned SIW        = (MXCLUSTERS > 1) ? $clog2(MXCLUSTERS) : 1;
  localparam logic [SIW-1:0] LAST_SLOT = SIW'(MXCLUSTERS - 1);
  localparam logic [MXCLSTBITS-1:0] INVALID = {{MXCNTBITS{1'b0}}, {MXADRBITS{1'b1}}};

  typedef enum logic [1:0] {IDLE, LOAD, ENCODE, DONE} state_t;

  state_t                                   state;
  logic [NPADS-1:0]                         frame_q;
  logic                                     rev_q, trunc_q;
  logic [NPADS-1:0]                         vpf_q;
  logic [NPADS-1:0][MXCNTBITS-1:0]          cnt_q;
  logic [MXCLUSTERS-1:0][MXCLSTBITS-1:0]    work_q, clusters_q;
  logic [SIW-1:0]                           slot_q;
  logic [CCW-1:0]                           count_q, cluster_count_q;
  logic                                     busy_q, clusters_valid_q, overflow_q;
  logic [15:0]                              dropped_q;

  logic [NPADS-1:0]                         vpf_d;
  logic [NPADS-1:0][MXCNTBITS-1:0]          cnt_d;

  // Forward scan marks run/chunk starts; backward scan gives remaining run length per pad.
  always_comb begin
    int unsigned pos, run, idx;
    vpf_d = '0;
    cnt_d = '0;
    pos   = 0;
    run   = 0;
    idx   = 0;
    for (int unsigned r = 0; r < MXROWS; r++) begin
      pos = 0;
      for (int unsigned k = 0; k < MXKEYS; k++) begin
        idx = r * MXKEYS + k;
        if (frame_q[idx]) begin
          vpf_d[idx] = trunc_q ? (pos == 0) : (pos % CHUNK == 0);
          pos = pos + 1;
        end else begin
          pos = 0;
        end
      end
      run = 0;
      for (int unsigned kk = 0; kk < MXKEYS; kk++) begin
        idx = r * MXKEYS + (MXKEYS - 1 - kk);
        if (frame_q[idx]) begin
          run = run + 1;
          cnt_d[idx] = MXCNTBITS'(((run > CHUNK) ? CHUNK : run) - 1);
        end else begin
          run = 0;
        end
      end
    end
  end

  logic                                  found;
  int unsigned                           pick;
  logic [MXCNTBITS-1:0]                  pick_cnt;
  logic [MXCLSTBITS-1:0]                 word_d;
  logic [NPADS-1:0]                      vpf_clr;
  logic [MXCLUSTERS-1:0][MXCLSTBITS-1:0] work_d;

  // Forward order: first hit wins; reverse order: last (highest) hit wins.
  always_comb begin
    found    = 1'b0;
    pick     = 0;
    pick_cnt = '0;
    for (int unsigned i = 0; i < NPADS; i++) begin
      if (vpf_q[i] && (!found || rev_q)) begin
        found    = 1'b1;
        pick     = i;
        pick_cnt = cnt_q[i];
      end
    end
    word_d  = found ? {pick_cnt, MXADRBITS'(pick)} : INVALID;
    vpf_clr = vpf_q;
    if (found) vpf_clr[pick] = 1'b0;
    work_d = work_q;
    work_d[slot_q] = word_d;
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state            <= IDLE;
      frame_q          <= '0;
      rev_q            <= 1'b0;
      trunc_q          <= 1'b0;
      vpf_q            <= '0;
      cnt_q            <= '0;
      work_q           <= {MXCLUSTERS{INVALID}};
      clusters_q       <= {MXCLUSTERS{INVALID}};
      slot_q           <= '0;
      count_q          <= '0;
      cluster_count_q  <= '0;
      busy_q           <= 1'b0;
      clusters_valid_q <= 1'b0;
      overflow_q       <= 1'b0;
      dropped_q        <= '0;
    end else begin
      clusters_valid_q <= 1'b0;
      if (bus.sbits_valid && busy_q && dropped_q != 16'hFFFF)
        dropped_q <= dropped_q + 16'd1;
      case (state)
        IDLE: begin
          if (bus.sbits_valid) begin
            frame_q <= bus.sbits;
            rev_q   <= bus.reverse_priority_order;
            trunc_q <= bus.truncate_clusters;
            busy_q  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          vpf_q   <= vpf_d;
          cnt_q   <= cnt_d;
          slot_q  <= '0;
          count_q <= '0;
          state   <= ENCODE;
        end
        ENCODE: begin
          vpf_q   <= vpf_clr;
          work_q  <= work_d;
          count_q <= count_q + CCW'(found);
          slot_q  <= slot_q + SIW'(1);
          if (slot_q == LAST_SLOT) begin
            clusters_q       <= work_d;
            cluster_count_q  <= count_q + CCW'(found);
            overflow_q       <= |vpf_clr;
            clusters_valid_q <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.clusters_valid = clusters_valid_q;
  assign bus.clusters       = clusters_q;
  assign bus.cluster_count  = cluster_count_q;
  assign bus.overflow       = overflow_q;
  assign bus.dropped_cnt    = dropped_q;
endmodule

// File: tb/tb_cluster_packer_seq.sv
// Directed bench for cluster_packer_seq: hand-computed cluster words, latency,
// overflow, priority reversal, run splitting, drop accounting and async reset.
module tb_cluster_packer_seq;
  localparam int unsigned NP = 8 * 192;
  localparam logic [13:0] INV = 14'h07FF;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  cluster_packer_seq_if bus ();

  cluster_packer_seq dut (
    .clock4x        (clk),
    .global_reset_n (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_frame(input logic [NP-1:0] bits, input logic rev, input logic trn,
                            output int lat);
    @(posedge clk); #1;
    bus.sbits = bits;
    bus.reverse_priority_order = rev;
    bus.truncate_clusters = trn;
    bus.sbits_valid = 1'b1;
    @(posedge clk); #1;
    bus.sbits_valid = 1'b0;
    lat = 1;
    while (bus.clusters_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.clusters_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.clusters_valid); end
    vectors++; if (bus.cluster_count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.cluster_count); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    vectors++; if (bus.dropped_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_dropped got %0d want 0", bus.dropped_cnt); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (bus.clusters[i*14 +: 14] !== INV) begin
        miscompares++; $display("FAIL reset_slot%0d got %h want %h", i, bus.clusters[i*14 +: 14], INV);
      end
    end
  endtask

  task automatic test_single;
    logic [NP-1:0] f;
    int lat;
    f = '0; f[5] = 1'b1;
    send_frame(f, 1'b0, 1'b1, lat);
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL single_latency got %0d want 10", lat); end
    vectors++; if (bus.clusters[13:0] !== {3'd0, 11'd5}) begin miscompares++; $display("FAIL single_slot0 got %h want %h", bus.clusters[13:0], {3'd0, 11'd5}); end
    for (int i = 1; i < 8; i++) begin
      vectors++;
      if (bus.clusters[i*14 +: 14] !== INV) begin
        miscompares++; $display("FAIL single_slot%0d got %h want %h", i, bus.clusters[i*14 +: 14], INV);
      end
    end
    vectors++; if (bus.cluster_count !== 4'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", bus.cluster_count); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL single_overflow got %b want 0", bus.overflow); end
  endtask

  task automatic test_run;
    logic [NP-1:0] f;
    int lat;
    f = '0;
    for (int k = 10; k <= 13; k++) f[2*192 + k] = 1'b1;
    send_frame(f, 1'b0, 1'b1, lat);
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL run_latency got %0d want 10", lat); end
    vectors++; if (bus.clusters[13:0] !== {3'd3, 11'd394}) begin miscompares++; $display("FAIL run_slot0 got %h want %h", bus.clusters[13:0], {3'd3, 11'd394}); end
    vectors++; if (bus.cluster_count !== 4'd1) begin miscompares++; $display("FAIL run_count got %0d want 1", bus.cluster_count); end
  endtask

  task automatic test_overflow_priority;
    logic [NP-1:0] f;
    int lat;
    int adrs[10];
    adrs = '{3, 50, 100, 200, 300, 400, 500, 600, 700, 800};
    f = '0;
    for (int i = 0; i < 10; i++) f[adrs[i]] = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      send_frame(f, pass[0], 1'b0, lat);
      vectors++; if (lat !== 10) begin miscompares++; $display("FAIL ovf_latency rev=%0d got %0d want 10", pass, lat); end
      for (int i = 0; i < 8; i++) begin
        logic [13:0] expw;
        expw = {3'd0, 11'(pass == 0 ? adrs[i] : adrs[9 - i])};
        vectors++;
        if (bus.clusters[i*14 +: 14] !== expw) begin
          miscompares++; $display("FAIL ovf_slot%0d rev=%0d got %h want %h", i, pass, bus.clusters[i*14 +: 14], expw);
        end
      end
      vectors++; if (bus.cluster_count !== 4'd8) begin miscompares++; $display("FAIL ovf_count rev=%0d got %0d want 8", pass, bus.cluster_count); end
      vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag rev=%0d got %b want 1", pass, bus.overflow); end
    end
  endtask

  task automatic test_split;
    logic [NP-1:0] f;
    int lat;
    logic [13:0] exps[4];
    f = '0;
    for (int k = 0; k < 20; k++) f[192 + k] = 1'b1;
    send_frame(f, 1'b0, 1'b1, lat);
    vectors++; if (bus.clusters[13:0] !== {3'd7, 11'd192}) begin miscompares++; $display("FAIL trunc_slot0 got %h want %h", bus.clusters[13:0], {3'd7, 11'd192}); end
    vectors++; if (bus.clusters[27:14] !== INV) begin miscompares++; $display("FAIL trunc_slot1 got %h want %h", bus.clusters[27:14], INV); end
    vectors++; if (bus.cluster_count !== 4'd1) begin miscompares++; $display("FAIL trunc_count got %0d want 1", bus.cluster_count); end
    send_frame(f, 1'b0, 1'b0, lat);
    exps = '{{3'd7, 11'd192}, {3'd7, 11'd200}, {3'd3, 11'd208}, INV};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.clusters[i*14 +: 14] !== exps[i]) begin
        miscompares++; $display("FAIL split_slot%0d got %h want %h", i, bus.clusters[i*14 +: 14], exps[i]);
      end
    end
    vectors++; if (bus.cluster_count !== 4'd3) begin miscompares++; $display("FAIL split_count got %0d want 3", bus.cluster_count); end
  endtask

  task automatic test_row_boundary;
    logic [NP-1:0] f;
    int lat;
    f = '0; f[191] = 1'b1; f[192] = 1'b1;
    send_frame(f, 1'b0, 1'b0, lat);
    vectors++; if (bus.clusters[13:0] !== {3'd0, 11'd191}) begin miscompares++; $display("FAIL row_slot0 got %h want %h", bus.clusters[13:0], {3'd0, 11'd191}); end
    vectors++; if (bus.clusters[27:14] !== {3'd0, 11'd192}) begin miscompares++; $display("FAIL row_slot1 got %h want %h", bus.clusters[27:14], {3'd0, 11'd192}); end
    vectors++; if (bus.cluster_count !== 4'd2) begin miscompares++; $display("FAIL row_count got %0d want 2", bus.cluster_count); end
  endtask

  task automatic test_back_to_back;
    logic [NP-1:0] fa, fb;
    int lat;
    int extra;
    fa = '0; fa[3*192 + 7] = 1'b1;
    fb = '0; fb[0] = 1'b1; fb[1] = 1'b1;
    @(posedge clk); #1;
    bus.sbits = fa; bus.reverse_priority_order = 1'b0; bus.truncate_clusters = 1'b1;
    bus.sbits_valid = 1'b1;
    @(posedge clk); #1; bus.sbits_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.sbits = fb; bus.sbits_valid = 1'b1;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
    @(posedge clk); #1; bus.sbits_valid = 1'b0;
    lat = 4;
    while (bus.clusters_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL b2b_latency got %0d want 10", lat); end
    vectors++; if (bus.dropped_cnt !== 16'd1) begin miscompares++; $display("FAIL b2b_dropped got %0d want 1", bus.dropped_cnt); end
    vectors++; if (bus.clusters[13:0] !== {3'd0, 11'd583}) begin miscompares++; $display("FAIL b2b_slot0 got %h want %h", bus.clusters[13:0], {3'd0, 11'd583}); end
    vectors++; if (bus.cluster_count !== 4'd1) begin miscompares++; $display("FAIL b2b_count got %0d want 1", bus.cluster_count); end
    // strobe during the DONE cycle is also dropped
    bus.sbits_valid = 1'b1;
    @(posedge clk); #1; bus.sbits_valid = 1'b0;
    vectors++; if (bus.dropped_cnt !== 16'd2) begin miscompares++; $display("FAIL done_dropped got %0d want 2", bus.dropped_cnt); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL done_busy got %b want 0", bus.busy); end
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.clusters_valid === 1'b1) extra++;
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL drop_no_result got %0d strobes want 0", extra); end
  endtask

  task automatic test_reset_mid_encode;
    logic [NP-1:0] f;
    int lat;
    int extra;
    f = '0; f[40] = 1'b1;
    @(posedge clk); #1;
    bus.sbits = f; bus.reverse_priority_order = 1'b0; bus.truncate_clusters = 1'b1;
    bus.sbits_valid = 1'b1;
    @(posedge clk); #1; bus.sbits_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    vectors++; if (bus.cluster_count !== 4'd0) begin miscompares++; $display("FAIL midrst_count got %0d want 0", bus.cluster_count); end
    vectors++; if (bus.dropped_cnt !== 16'd0) begin miscompares++; $display("FAIL midrst_dropped got %0d want 0", bus.dropped_cnt); end
    vectors++; if (bus.clusters[13:0] !== INV) begin miscompares++; $display("FAIL midrst_slot0 got %h want %h", bus.clusters[13:0], INV); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.clusters_valid === 1'b1) extra++;
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL midrst_no_result got %0d strobes want 0", extra); end
    send_frame(f, 1'b0, 1'b1, lat);
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL postrst_latency got %0d want 10", lat); end
    vectors++; if (bus.clusters[13:0] !== {3'd0, 11'd40}) begin miscompares++; $display("FAIL postrst_slot0 got %h want %h", bus.clusters[13:0], {3'd0, 11'd40}); end
    vectors++; if (bus.cluster_count !== 4'd1) begin miscompares++; $display("FAIL postrst_count got %0d want 1", bus.cluster_count); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.sbits_valid = 1'b0;
    bus.sbits = '0;
    bus.reverse_priority_order = 1'b0;
    bus.truncate_clusters = 1'b1;
    #23;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    test_single;
    test_run;
    test_overflow_priority;
    test_split;
    test_row_boundary;
    test_back_to_back;
    test_reset_mid_encode;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
